// File: rtl/palette_pkg.sv
// Shared constants and types for the true-color to xterm palette index encoder.
// Level and threshold tables describe the 6-step cube axis used on every channel.
package palette_pkg;

    typedef logic [7:0] pal_idx_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam pal_idx_t PAL_CUBE_BASE  = 8'd16;
    localparam pal_idx_t PAL_GRAY_BASE  = 8'd232;
    localparam int       PAL_GRAY_STEPS = 24;

    // Element [0] is the darkest level; thresholds are the last value mapping to level i.
    localparam logic [5:0][7:0] PAL_LEVEL_VAL = {8'd255, 8'd215, 8'd175, 8'd135, 8'd95, 8'd0};
    localparam logic [4:0][7:0] PAL_LEVEL_THR = {8'd235, 8'd195, 8'd155, 8'd115, 8'd47};

    function automatic logic [15:0] sq_diff(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return 16'(d) * 16'(d);
    endfunction

endpackage

// File: rtl/palette_level_quant.sv
// Maps one 8-bit channel value onto the nearest of the six cube levels.
// Ties between two levels resolve to the lower level through the threshold table.
module palette_level_quant
    import palette_pkg::*;
(
    input  logic [7:0] value_i,
    output logic [2:0] level_o,
    output logic [7:0] level_val_o
);

    always_comb begin
        level_o = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (value_i > PAL_LEVEL_THR[i]) begin
                level_o = 3'(i + 1);
            end
        end
    end

    always_comb begin
        case (level_o)
            3'd0:    level_val_o = PAL_LEVEL_VAL[0];
            3'd1:    level_val_o = PAL_LEVEL_VAL[1];
            3'd2:    level_val_o = PAL_LEVEL_VAL[2];
            3'd3:    level_val_o = PAL_LEVEL_VAL[3];
            3'd4:    level_val_o = PAL_LEVEL_VAL[4];
            default: level_val_o = PAL_LEVEL_VAL[5];
        endcase
    end

endmodule

// File: rtl/palette_encoder.sv
// Nearest-color encoder: 24-bit RGB in, xterm 256-color index (16..255) out.
// Input capture rank followed by quantize, distance and select ranks; all advance together.
module palette_encoder
    import palette_pkg::*;
#(
    parameter logic GRAY_EN = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [23:0] rgb_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  index_out,
    output logic        out_valid,
    input  logic        out_ready
);

    // valid/ready: a transfer happens on a rising edge where valid && ready are both high;
    // the whole pipe freezes while the output holds a pixel the consumer has not taken.
    logic     rst_done_q;
    logic     stall;
    logic     advance;

    logic     v0_q;
    rgb_t     px0_q;

    logic     v1_q;
    rgb_t     px1_q;
    rgb_t     lvv1_q;
    logic [2:0] lr1_q, lg1_q, lb1_q;
    logic [9:0] sum1_q;

    logic     v2_q;
    logic [4:0] k2_q;
    pal_idx_t cube2_q;
    logic [17:0] dc2_q, dg2_q;

    logic     out_valid_q;
    pal_idx_t index_q;

    logic [2:0] lr_d, lg_d, lb_d;
    rgb_t     lvv_d;
    logic [9:0] sum_d;
    logic [4:0] k_d;
    logic [7:0] gv_d;
    logic [17:0] dc_d, dg_d;
    pal_idx_t cube_d;
    pal_idx_t index_d;

    assign stall     = out_valid_q && !out_ready;
    assign advance   = !stall;
    assign in_ready  = Reset_n && rst_done_q && !stall;
    assign out_valid = out_valid_q;
    assign index_out = index_q;

    palette_level_quant u_quant_r (
        .value_i     (px0_q.r),
        .level_o     (lr_d),
        .level_val_o (lvv_d.r)
    );

    palette_level_quant u_quant_g (
        .value_i     (px0_q.g),
        .level_o     (lg_d),
        .level_val_o (lvv_d.g)
    );

    palette_level_quant u_quant_b (
        .value_i     (px0_q.b),
        .level_o     (lb_d),
        .level_val_o (lvv_d.b)
    );

    assign sum_d = 10'(px0_q.r) + 10'(px0_q.g) + 10'(px0_q.b);

    // Gray step k = min(floor((S-9)/30), 23), counted as crossed step boundaries.
    always_comb begin
        k_d = 5'd0;
        for (int j = 1; j < PAL_GRAY_STEPS; j++) begin
            if (sum1_q >= 10'(9 + 30 * j)) begin
                k_d = k_d + 5'd1;
            end
        end
    end

    always_comb begin
        gv_d   = 8'd8 + ({3'b000, k_d} << 3) + ({3'b000, k_d} << 1);
        dc_d   = 18'(sq_diff(px1_q.r, lvv1_q.r)) + 18'(sq_diff(px1_q.g, lvv1_q.g))
               + 18'(sq_diff(px1_q.b, lvv1_q.b));
        dg_d   = 18'(sq_diff(px1_q.r, gv_d)) + 18'(sq_diff(px1_q.g, gv_d))
               + 18'(sq_diff(px1_q.b, gv_d));
        cube_d = PAL_CUBE_BASE + ({5'b00000, lr1_q} * 8'd36) + ({5'b00000, lg1_q} * 8'd6)
               + {5'b00000, lb1_q};
    end

    // Equal distances keep the cube entry.
    always_comb begin
        index_d = cube2_q;
        if (GRAY_EN && (dg2_q < dc2_q)) begin
            index_d = PAL_GRAY_BASE + {3'b000, k2_q};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rst_done_q  <= 1'b0;
            v0_q        <= 1'b0;
            px0_q       <= '0;
            v1_q        <= 1'b0;
            px1_q       <= '0;
            lvv1_q      <= '0;
            lr1_q       <= 3'd0;
            lg1_q       <= 3'd0;
            lb1_q       <= 3'd0;
            sum1_q      <= 10'd0;
            v2_q        <= 1'b0;
            k2_q        <= 5'd0;
            cube2_q     <= '0;
            dc2_q       <= 18'd0;
            dg2_q       <= 18'd0;
            out_valid_q <= 1'b0;
            index_q     <= '0;
        end else begin
            rst_done_q <= 1'b1;
            if (advance) begin
                v0_q        <= in_valid && in_ready;
                px0_q       <= rgb_t'(rgb_in);
                v1_q        <= v0_q;
                px1_q       <= px0_q;
                lvv1_q      <= lvv_d;
                lr1_q       <= lr_d;
                lg1_q       <= lg_d;
                lb1_q       <= lb_d;
                sum1_q      <= sum_d;
                v2_q        <= v1_q;
                k2_q        <= k_d;
                cube2_q     <= cube_d;
                dc2_q       <= dc_d;
                dg2_q       <= dg_d;
                out_valid_q <= v2_q;
                index_q     <= index_d;
            end
        end
    end

endmodule

// File: tb/tb_palette_encoder.sv
// Bench for palette_encoder: gray-enabled and cube-only instances share one stimulus stream.
// Expected indices come from a brute-force nearest-color model pushed on every accepted pixel.
module tb_palette_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] rgb;
    logic        in_valid;
    logic        out_ready;
    logic        in_ready, out_valid;
    logic [7:0]  index_out;
    logic        in_ready_ng, out_valid_ng;
    logic [7:0]  index_ng;

    always #5 clk = ~clk;

    palette_encoder #(.GRAY_EN(1'b1)) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .rgb_in    (rgb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .index_out (index_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    palette_encoder #(.GRAY_EN(1'b0)) dut_ng (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .rgb_in    (rgb),
        .in_valid  (in_valid),
        .in_ready  (in_ready_ng),
        .index_out (index_ng),
        .out_valid (out_valid_ng),
        .out_ready (out_ready)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_ng_q[$];
    logic       acc_last = 1'b0;
    logic       stalled_last = 1'b0;
    logic [7:0] held_idx = 8'd0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Nearest cube level by direct search, gray step by plain division.
    function automatic logic [7:0] ref_index(input logic [23:0] px, input bit gray_en);
        int c[3];
        int lv[6];
        int lvl[3];
        int s, k, gv, dc, dg, best;
        lv = '{0, 95, 135, 175, 215, 255};
        c[0] = int'(px[23:16]);
        c[1] = int'(px[15:8]);
        c[2] = int'(px[7:0]);
        dc = 0;
        dg = 0;
        s = c[0] + c[1] + c[2];
        for (int ch = 0; ch < 3; ch++) begin
            best = 0;
            for (int l = 1; l < 6; l++) begin
                if (iabs(c[ch] - lv[l]) < iabs(c[ch] - lv[best])) best = l;
            end
            lvl[ch] = best;
            dc += (c[ch] - lv[best]) * (c[ch] - lv[best]);
        end
        k = (s < 9) ? 0 : (s - 9) / 30;
        if (k > 23) k = 23;
        gv = 8 + 10 * k;
        for (int ch = 0; ch < 3; ch++) dg += (c[ch] - gv) * (c[ch] - gv);
        if (gray_en && dg < dc) return 8'(232 + k);
        return 8'(16 + 36 * lvl[0] + 6 * lvl[1] + lvl[2]);
    endfunction

    // One clock: observe at the falling edge, then return 1 time unit after the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (rst_n) begin
            acc_last = in_valid && in_ready;
            if (stalled_last) begin
                check("stall_hold_idx", index_out, held_idx);
                check("stall_hold_valid", out_valid, 1);
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready, 0);
                stalled_last = 1'b1;
                held_idx = index_out;
            end else begin
                stalled_last = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
                else check("index", index_out, exp_q.pop_front());
            end
            if (out_valid_ng && out_ready) begin
                if (exp_ng_q.size() == 0) check("spurious_out_ng", out_valid_ng, 0);
                else check("index_ng", index_ng, exp_ng_q.pop_front());
            end
            if (acc_last) begin
                exp_q.push_back(ref_index(rgb, 1'b1));
                exp_ng_q.push_back(ref_index(rgb, 1'b0));
            end
        end else begin
            exp_q.delete();
            exp_ng_q.delete();
            acc_last = 1'b0;
            stalled_last = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || exp_ng_q.size() != 0); i++) cycle();
        check("drain_empty", exp_q.size(), 0);
        check("drain_empty_ng", exp_ng_q.size(), 0);
    endtask

    function automatic logic [7:0] pick_chan();
        logic [7:0] bvals[12];
        bvals = '{8'd0, 8'd47, 8'd48, 8'd115, 8'd116, 8'd155, 8'd156, 8'd195, 8'd196,
                  8'd235, 8'd236, 8'd255};
        if ($urandom_range(0, 3) == 0) return bvals[$urandom_range(0, 11)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] stream[4];
        logic [23:0] bnd[5];
        logic [23:0] bp[6];
        logic [7:0]  g;
        int          idx;

        rst_n = 1'b0;
        rgb = 24'h0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_index", index_out, 0);
        check("rst_out_valid_ng", out_valid_ng, 0);
        rst_n = 1'b1;
        check("in_ready_at_release", in_ready, 0);
        cycle();
        check("in_ready_after_release", in_ready, 1);

        // Single black pixel: visible exactly three edges after acceptance.
        rgb = 24'h000000;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        check("latency_early", out_valid, 0);
        cycle();
        check("latency_valid", out_valid, 1);
        check("black_index", index_out, ref_index(24'h000000, 1'b1));
        drain();

        stream = '{24'hFFFFFF, 24'hFF0000, 24'h808080, 24'h737373};
        for (int i = 0; i < 4; i++) begin
            rgb = stream[i];
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("b2b_valid", out_valid, 1);
            check("b2b_index", index_out, ref_index(stream[i], 1'b1));
            cycle();
        end
        drain();

        bnd = '{24'h808080, 24'h737373, 24'h747474, 24'h2F2F2F, 24'h303030};
        for (int i = 0; i < 5; i++) begin
            rgb = bnd[i];
            in_valid = 1'b1;
            cycle();
        end
        drain();

        // Five-cycle output stall in the middle of six distinct pixels.
        bp = '{24'h102030, 24'hC0FFEE, 24'h5F87AF, 24'h0A0A0A, 24'hEEEEEE, 24'h31D700};
        idx = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            in_valid = (idx < 6);
            rgb = (idx < 6) ? bp[idx] : 24'h0;
            cycle();
            if (acc_last) idx++;
        end
        check("bp_all_accepted", idx, 6);
        drain();

        // Reset with three pixels in flight.
        for (int i = 0; i < 3; i++) begin
            rgb = 24'h404040 + 24'(i * 24'h111111);
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("midrst_out_valid", out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("midrst_no_stale", out_valid, 0);
        end

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!(in_valid && !acc_last)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0) begin
                    g = pick_chan();
                    rgb = {g, g, g};
                end else begin
                    rgb = {pick_chan(), pick_chan(), pick_chan()};
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
